// File: rtl/spi_arb_pkg.sv
// Shared constants for the SPI requester arbiter: default parameters and FSM encoding.
package spi_arb_pkg;

  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned DEF_DATA_BW        = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE_ENC = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_ENC  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_ISSUE = ST_ISSUE_ENC,
    ST_WAIT  = ST_WAIT_ENC,
    ST_DONE  = ST_DONE_ENC
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first set request at or after ptr, as one-hot and index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0]   idx_c
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Scan NUM_REQ positions starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = IDX_W'(sum);
      if (!found && req[cand]) begin
        found       = 1'b1;
        gnt_c[cand] = 1'b1;
        idx_c       = cand;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spi_controller between NUM_REQ requesters, one word per grant.
// Optional watchdog on the WAIT state: define SPI_ARB_TIMEOUT_EN.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned DATA_BW        = DEF_DATA_BW,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*DATA_BW-1:0] i_req_data,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [NUM_REQ-1:0]         o_rsp_valid,
  output logic [DATA_BW-1:0]         o_rsp_data,
  output logic [NUM_REQ-1:0]         o_cs_n,
  output logic                       o_busy,
  output logic                       o_timeout,
  output logic                       o_spi_tx_en,
  output logic [DATA_BW-1:0]         o_spi_tx_data,
  input  logic                       i_spi_tx_ready,
  input  logic                       i_spi_rx_ack,
  input  logic [DATA_BW-1:0]         i_spi_rx_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("spi_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES nonzero");
  end

  arb_state_t         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   sel_idx;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [DATA_BW-1:0] word;

  logic [NUM_REQ-1:0] rr_gnt_c;
  logic [IDX_W-1:0]   rr_idx_c;
  logic [DATA_BW-1:0] req_word_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (i_req),
    .ptr   (ptr),
    .gnt_c (rr_gnt_c),
    .idx_c (rr_idx_c)
  );

  // TX word of the requester the round-robin would pick this cycle.
  always_comb begin
    req_word_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (rr_idx_c == IDX_W'(k)) begin
        req_word_c = i_req_data[k*DATA_BW +: DATA_BW];
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_q;
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      sel_idx       <= '0;
      sel_onehot    <= '0;
      word          <= '0;
      o_grant       <= '0;
      o_rsp_valid   <= '0;
      o_rsp_data    <= '0;
      o_cs_n        <= '1;
      o_busy        <= 1'b0;
      o_spi_tx_en   <= 1'b0;
      o_spi_tx_data <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt       <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      o_grant     <= '0;
      o_rsp_valid <= '0;
      o_spi_tx_en <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (|i_req && i_spi_tx_ready) begin
            sel_idx    <= rr_idx_c;
            sel_onehot <= rr_gnt_c;
            word       <= req_word_c;
            o_grant    <= rr_gnt_c;
            o_cs_n     <= ~rr_gnt_c;
            o_busy     <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          o_spi_tx_en   <= 1'b1;
          o_spi_tx_data <= word;
`ifdef SPI_ARB_TIMEOUT_EN
          tmo_cnt       <= '0;
`endif
          state         <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_spi_rx_ack) begin
            o_rsp_data  <= i_spi_rx_data;
            o_rsp_valid <= sel_onehot;
            state       <= ST_DONE;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_q <= 1'b1;
            state     <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        ST_DONE: begin
          // Chip select stays low until the controller is ready again.
          if (i_spi_tx_ready) begin
            o_cs_n <= '1;
            ptr    <= (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter DATA_BW, default 8: SPI word width, equal to the attached spi_controller DATA_BW.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit in i_clk cycles, used only when SPI_ARB_TIMEOUT_EN is defined.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 i_clk  in  1  system clock.
REQ-006 i_rst  in  1  asynchronous active-high reset.
REQ-007 i_req  in  NUM_REQ  per-requester transfer request, level, held until granted.
REQ-008 i_req_data  in  NUM_REQ*DATA_BW  per-requester TX word; requester k occupies bits [k*DATA_BW +: DATA_BW].
REQ-009 o_grant  out  NUM_REQ  one-hot, one-cycle pulse: request accepted.
REQ-010 o_rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: o_rsp_data is valid for that requester.
REQ-011 o_rsp_data  out  DATA_BW  received word, shared across requesters.
REQ-012 o_cs_n  out  NUM_REQ  per-device chip select, active-low.
REQ-013 o_busy  out  1  high in any state other than IDLE.
REQ-014 o_timeout  out  1  one-cycle pulse: transfer aborted by the watchdog.
REQ-015 o_spi_tx_en  out  1  start pulse to spi_controller i_tx_en.
REQ-016 o_spi_tx_data  out  DATA_BW  word to spi_controller i_tx_data.
REQ-017 i_spi_tx_ready  in  1  from spi_controller o_tx_ready.
REQ-018 i_spi_rx_ack  in  1  from spi_controller o_rx_ack.
REQ-019 i_spi_rx_data  in  DATA_BW  from spi_controller o_rx_data.

Function
REQ-020 The FSM SHALL use the states IDLE, ISSUE, WAIT and DONE, all registered.
REQ-021 IDLE: when |i_req and i_spi_tx_ready are both high at a clock edge, the block SHALL select requester k round-robin starting at pointer ptr.
- On that edge it SHALL latch k and i_req_data slice k, pulse o_grant[k], drive o_cs_n[k] low, and move to ISSUE.
REQ-022 ISSUE: the block SHALL assert o_spi_tx_en for exactly one cycle with o_spi_tx_data equal to the latched word, then move to WAIT.
REQ-023 WAIT: on i_spi_rx_ack, the block SHALL register i_spi_rx_data into o_rsp_data, pulse o_rsp_valid[k] on the next cycle, and move to DONE.
REQ-024 DONE: the block SHALL drive o_cs_n[k] high, set ptr to k+1 (NUM_REQ-1 wraps to 0), and return to IDLE only once i_spi_tx_ready is high.
REQ-025 Latency: o_grant edge to o_spi_tx_en SHALL be 1 cycle; i_spi_rx_ack to o_rsp_valid SHALL be 1 cycle.
REQ-026 At most one o_cs_n bit SHALL be low at any time, and only from the grant edge until the DONE exit.
REQ-027 Requests arriving or changing while o_busy is high SHALL be ignored until IDLE; a request deasserted before its grant SHALL be dropped silently.
REQ-028 When all requesters request continuously, each SHALL be granted exactly once per NUM_REQ transfers.
REQ-029 i_spi_rx_ack outside WAIT SHALL be ignored.
REQ-030 The block SHALL stay in IDLE while i_spi_tx_ready is low, regardless of i_req.

Reset
REQ-031 Under i_rst the block SHALL set state=IDLE, ptr=0, o_cs_n all 1, and every other output to 0, effective immediately, including mid-transfer.

Configuration
REQ-032 With SPI_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT.
- On reaching TIMEOUT_CYCLES without i_spi_rx_ack, the block SHALL pulse o_timeout, suppress o_rsp_valid, and go to DONE.
- The counter SHALL clear on every entry to WAIT.
REQ-033 Without SPI_ARB_TIMEOUT_EN, WAIT SHALL persist until i_spi_rx_ack, o_timeout SHALL be tied 0, and no counter logic SHALL be present.

Structure
REQ-034 The state encoding localparams and the default-parameter constants SHALL live in the shared package spi_arb_pkg.
REQ-035 The round-robin priority selection (req vector plus ptr to one-hot and index) SHALL be the sub-module rr_arbiter.

Verification
REQ-036 Single request: i_req=4'b0100, data 8'hA5, MISO loopback -> o_grant=4'b0100, o_cs_n[2]=0 during the transfer, o_rsp_valid=4'b0100, o_rsp_data=8'hA5.
REQ-037 All four requesting from reset -> grant order 0,1,2,3,0; o_spi_tx_en is one cycle per transfer.
REQ-038 i_spi_tx_ready held low with i_req=4'b0001 -> no grant; grant follows 1 cycle after ready rises.
REQ-039 i_rst pulsed during WAIT -> o_cs_n=4'b1111, o_busy=0, and the next grant goes to requester 0.
REQ-040 SPI_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and i_spi_rx_ack never asserted -> o_timeout pulse 16 cycles after WAIT entry, no o_rsp_valid, return to IDLE.
